// File: rtl/bcd_time_entry_pkg.sv
// Shared constants and state type for the decimal time-entry block.
// Optional TIME_ENTRY_AUTOCLEAR_EN is consumed by bcd_time_entry.
package time_entry_pkg;
  localparam int NUM_DIGITS = 3;
  localparam int BIN_BITS   = 10;
  localparam int ITER_LAST  = 9;
  localparam int BCD_BITS   = 4 * NUM_DIGITS;
  localparam int SR_BITS    = BCD_BITS + BIN_BITS;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ        = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;
endpackage

// File: rtl/bcd_time_entry_if.sv
// Entry/result bundle between the keypad front end and the timer.
// master drives keypad strobes, slave is the converter.
interface bcd_time_entry_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       digit_in;
  logic             digit_valid;
  logic             clear;
  logic             commit;
  logic [11:0]      entry_digits;
  logic             busy;
  logic [WIDTH-1:0] time_value;
  logic             value_valid;
  logic             overflow;

  modport master (
    output digit_in, digit_valid, clear, commit,
    input  entry_digits, busy, time_value,
    input  value_valid, overflow
  );

  modport slave (
    input  digit_in, digit_valid, clear, commit,
    output entry_digits, busy, time_value,
    output value_valid, overflow
  );
endinterface

// File: rtl/bcd_time_entry_sub3.sv
// Reverse double-dabble nibble correction: subtract 3 when >= 8.
// Purely combinational.
module sub3
  import time_entry_pkg::*;
(
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = (nib >= BCD_ADJ_THRESH) ? nib - BCD_ADJ : nib;
endmodule

// File: rtl/bcd_time_entry.sv
// Decimal keypad entry with sequential BCD-to-binary conversion.
// Define TIME_ENTRY_AUTOCLEAR_EN to zero the entry on completion.
module bcd_time_entry
  import time_entry_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 255
) (
  input logic              CLOCK_50,
  input logic              reset_n,
  bcd_time_entry_if.slave  bus
);
  if (MAX_VALUE > (2 ** WIDTH) - 1) begin : g_bad_max
    $error("MAX_VALUE does not fit in WIDTH bits");
  end

  state_t               state, state_nxt;
  logic [SR_BITS-1:0]   shreg, shifted, adj;
  logic [3:0]           iter;
  logic [BCD_BITS-1:0]  entry;
  logic [WIDTH-1:0]     value;
  logic                 vld, ovf, sat;
  logic [BIN_BITS-1:0]  bin;

  assign shifted = {1'b0, shreg[SR_BITS-1:1]};
  assign adj[BIN_BITS-1:0] = shifted[BIN_BITS-1:0];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    sub3 u_sub3 (
      .nib (shifted[BIN_BITS+4*g +: 4]),
      .adj (adj[BIN_BITS+4*g +: 4])
    );
  end

  assign bin = shreg[BIN_BITS-1:0];
  assign sat = {{(32-BIN_BITS){1'b0}}, bin} > 32'(MAX_VALUE);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!bus.clear && bus.commit) state_nxt = CONV;
      CONV: if (iter == ITER_LAST[3:0])   state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      iter  <= '0;
      entry <= '0;
      value <= '0;
      vld   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.clear) begin
            entry <= '0;
          end else if (bus.commit) begin
            shreg <= {entry, {BIN_BITS{1'b0}}};
            iter  <= '0;
          end else if (bus.digit_valid && bus.digit_in <= 4'd9) begin
            entry <= {entry[BCD_BITS-5:0], bus.digit_in};
          end
        end
        CONV: begin
          shreg <= adj;
          iter  <= iter + 4'd1;
        end
        DONE: begin
          value <= sat ? WIDTH'(MAX_VALUE) : WIDTH'(bin);
          ovf   <= sat;
          vld   <= 1'b1;
`ifdef TIME_ENTRY_AUTOCLEAR_EN
          entry <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.entry_digits = entry;
  assign bus.busy         = (state != IDLE);
  assign bus.time_value   = value;
  assign bus.value_valid  = vld;
  assign bus.overflow     = ovf;
endmodule
